data_mem_stage: RTL
===================

# data_mem_stage

Memory-access (M) stage of the 5-stage pipelined MIPS core, directly downstream of the EX/MEM pipeline register. It consumes the registered M-stage controls, address and store data, and holds a word-addressed data RAM. A wait-state counter models a configurable access latency and drives a stall request to the hazard unit. It returns load data to the MEM/WB register and flags misaligned accesses.

## Interface
- AW, default 8: word-address width; RAM depth is 2^AW 32-bit words.
- LATENCY, default 2: cycles per access, legal range 1..15; 1 means single-cycle with no stall.
- CLK  in  1  rising-edge clock.
- rst  in  1  asynchronous, active-low reset.
- MemWriteM  in  1  store request.
- MemtoRegM  in  1  load request.
- ALUOutM  in  32  byte address; word index is ALUOutM[AW+1:2].
- WriteDataM  in  32  store data.
- ReadDataM  out  32  load data (combinational).
- StallM  out  1  freeze request to the hazard unit (combinational).
- MisalignM  out  1  current request has ALUOutM[1:0] != 0 (combinational).
- AddrErrM  out  1  sticky misalignment flag.

## Operation
- req = MemWriteM | MemtoRegM.
- mis = req & (ALUOutM[1:0] != 0).
- A valid access is req & ~mis.
- RAM is not reset. Word index uses ALUOutM[AW+1:2]; upper address bits are ignored, so addresses wrap modulo 2^AW words.
- FSM states: IDLE and WAIT, with a 4-bit counter cnt.
  - IDLE, valid access, LATENCY > 1: StallM = 1; next state WAIT, cnt <= 1.
  - IDLE, valid access, LATENCY = 1: StallM = 0; a store commits at this edge; stay IDLE.
  - WAIT, cnt < LATENCY-1: StallM = 1; cnt <= cnt+1.
  - WAIT, cnt = LATENCY-1: StallM = 0 (final cycle); a store commits at this edge; next state IDLE, cnt <= 0.
  - WAIT, req deasserted (flush): StallM = 0; next state IDLE; no write.
- The hazard unit freezes the F, D, E and M registers and bubbles W while StallM = 1. Inputs are therefore stable during WAIT.
- Stores commit only on the final-cycle edge, never earlier.
- ReadDataM:
  - RAM[index] when MemtoRegM & ~mis & ~StallM.
  - 0 otherwise, including while stalled and for misaligned requests.
- If MemWriteM and MemtoRegM are both 1, the store takes precedence. ReadDataM shows the pre-write word in the final cycle.
- Misaligned request: MisalignM = 1 for that cycle, no RAM access, StallM = 0, FSM stays IDLE.
- AddrErrM is set on the edge where mis = 1. It clears only on reset.
- Back-to-back accesses: after the final cycle the FSM is in IDLE. The next request starts a fresh access with no idle gap.

## Timing
- Reset values, applied asynchronously on rst low: state = IDLE, cnt = 0, AddrErrM = 0.
- Outputs while in reset: StallM = 0 and ReadDataM = 0. MisalignM follows its inputs.
- Reset during WAIT aborts the access: no write occurs and RAM contents are retained.
- Access latency is exactly LATENCY cycles from the first cycle req is seen in IDLE.
- StallM is high for LATENCY-1 consecutive cycles and low in the final cycle.
- Load data is valid in the final cycle and is captured by MEM/WB at the closing edge.
- A store is visible to a load whose final cycle falls in the cycle after the store commits.
- A non-memory instruction (req = 0) never stalls and passes in 1 cycle.

## Test plan
- LATENCY=2, AW=8:
  - Store 0xDEADBEEF to address 0x10, held for its access: StallM = 1 for 1 cycle, then 0.
  - Then load 0x10: StallM = 1 for 1 cycle; ReadDataM = 0xDEADBEEF in the final cycle and 0 while stalled.
- LATENCY=4, back-to-back:
  - Store 0x11 to 0x0 immediately followed by a load of 0x0.
  - Required: StallM pattern 1,1,1,0,1,1,1,0; the load returns 0x11; no idle cycle between the accesses.
- Misaligned load at 0x13: MisalignM = 1, StallM = 0, ReadDataM = 0, AddrErrM = 1 from the next edge; a subsequent aligned access behaves normally.
- Reset mid-WAIT (LATENCY=4):
  - Store 0xCAFE to 0x20; pull rst low in the 2nd cycle.
  - Required: StallM = 0 immediately; after reset a load of 0x20 returns the prior contents, not 0xCAFE.
- Wrap and precedence (AW=8):
  - Store 0xA5 to 0x400 (aliases index 0), then load 0x0: returns 0xA5.
  - MemWriteM and MemtoRegM both high with 0x5A to 0x0: ReadDataM = 0xA5 in the final cycle; a later load returns 0x5A.
- LATENCY=1: a store then a load to 0x8 with data 0x1234: StallM stays 0 throughout and the load returns 0x1234 in one cycle.

Source files
------------

// File: rtl/data_mem_stage.sv
// data_mem_stage: MIPS pipeline memory-access stage.
// Word-addressed data RAM behind a wait-state FSM. The FSM requests a stall
// for LATENCY-1 cycles and commits stores only in the final access cycle.
// Loads read combinationally so MEM/WB captures the word at the closing edge.
// Misaligned requests are rejected without touching the RAM and set a sticky
// error flag.
// LATENCY must lie in 1..15 because the wait counter is 4 bits wide.
module data_mem_stage #(
  parameter int AW      = 8,
  parameter int LATENCY = 2
) (
  input  logic        CLK,
  input  logic        rst,         // asynchronous, active-low
  input  logic        MemWriteM,
  input  logic        MemtoRegM,
  input  logic [31:0] ALUOutM,
  input  logic [31:0] WriteDataM,
  output logic [31:0] ReadDataM,
  output logic        StallM,
  output logic        MisalignM,
  output logic        AddrErrM
);

  typedef enum logic {
    S_IDLE = 1'b0,
    S_WAIT = 1'b1
  } state_e;

  // Counter value of the final access cycle.
  localparam logic [3:0] LAST_CNT = 4'(LATENCY - 1);

  // A latency of 1 never enters WAIT.
  localparam bit MULTI_CYCLE = (LATENCY > 1);

  state_e          state_q, state_d;
  logic   [3:0]    cnt_q, cnt_d;
  logic            addr_err_q, addr_err_d;

  logic            req;
  logic            mis;
  logic            valid_acc;
  logic            stall_raw;
  logic            final_cycle;
  logic            mem_we;
  logic   [AW-1:0] word_idx;

  // Data RAM: deliberately not reset, so contents survive a reset.
  logic   [31:0]   ram_q [2**AW];

  // Address bits above the word index are ignored, so addresses wrap.
  logic            unused_addr_bits;
  assign unused_addr_bits = ^ALUOutM[31:AW+2];

  assign req       = MemWriteM | MemtoRegM;
  assign mis       = req & (ALUOutM[1:0] != 2'b00);
  assign valid_acc = req & ~mis;
  assign word_idx  = ALUOutM[AW+1:2];

  // Next-state / stall decode of the wait-state FSM.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    stall_raw   = 1'b0;
    final_cycle = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (valid_acc) begin
          if (MULTI_CYCLE) begin
            stall_raw = 1'b1;
            state_d   = S_WAIT;
            cnt_d     = 4'd1;
          end else begin
            final_cycle = 1'b1;
          end
        end
      end
      S_WAIT: begin
        if (!valid_acc) begin
          // Request withdrawn (flush): abandon the access without writing.
          state_d = S_IDLE;
          cnt_d   = 4'd0;
        end else if (cnt_q < LAST_CNT) begin
          stall_raw = 1'b1;
          cnt_d     = cnt_q + 4'd1;
        end else begin
          final_cycle = 1'b1;
          state_d     = S_IDLE;
          cnt_d       = 4'd0;
        end
      end
      default: begin
        state_d = S_IDLE;
        cnt_d   = 4'd0;
      end
    endcase
  end

  // The sticky error flag sets on any edge that sees a misaligned request.
  assign addr_err_d = addr_err_q | mis;

  // FSM state, wait counter and sticky error flag.
  always_ff @(posedge CLK or negedge rst) begin
    if (!rst) begin
      state_q    <= S_IDLE;
      cnt_q      <= 4'd0;
      addr_err_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      addr_err_q <= addr_err_d;
    end
  end

  // Gating with rst keeps a store from landing while reset is held.
  assign mem_we = final_cycle & MemWriteM & rst;

  // RAM write port: a store commits only on its final-cycle edge.
  always_ff @(posedge CLK) begin
    if (mem_we) begin
      ram_q[word_idx] <= WriteDataM;
    end
  end

  // While stalled the read is masked. When a load and a store hit together,
  // the store wins and the read returns the pre-write word in the final cycle.
  assign StallM    = stall_raw & rst;
  assign ReadDataM = (MemtoRegM & ~mis & ~StallM & rst) ? ram_q[word_idx] : 32'd0;
  assign MisalignM = mis;
  assign AddrErrM  = addr_err_q;

endmodule
